priority_arbiter8: RTL and testbench

PRIORITY_ARBITER8 -- requirements
Module: priority_arbiter8

---
 rtl/priority_arbiter8.sv | 110 +++++++++++
 tb/tb_priority_arbiter8.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter8.sv
// Eight-way arbiter with fixed or round-robin priority, a bounded grant length
// and a mandatory RELEASE cycle between grants; all outputs are registered.
module priority_arbiter8 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       hold_expired
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t     state, next_state;
    logic [3:0] hold_cnt, next_hold_cnt;
    logic [2:0] last_id, next_last_id;
    logic [7:0] next_gnt;
    logic [2:0] next_gnt_id;
    logic       next_gnt_valid;
    logic       next_hold_expired;
    logic [2:0] winner;

    // Later loop hits overwrite earlier ones, so the loops run from lowest to highest priority.
    always_comb begin
        winner = 3'd0;
        if (rr_en) begin
            for (int k = 8; k >= 1; k--) begin
                if (req[3'(int'(last_id) - k)]) begin
                    winner = 3'(int'(last_id) - k);
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) begin
                    winner = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt          <= 8'h00;
            gnt_id       <= 3'd0;
            gnt_valid    <= 1'b0;
            hold_expired <= 1'b0;
            hold_cnt     <= 4'd0;
            last_id      <= 3'd0;
        end else begin
            state        <= next_state;
            gnt          <= next_gnt;
            gnt_id       <= next_gnt_id;
            gnt_valid    <= next_gnt_valid;
            hold_expired <= next_hold_expired;
            hold_cnt     <= next_hold_cnt;
            last_id      <= next_last_id;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req != 8'h00) next_state = GRANT;
            GRANT:   if (!req[gnt_id] || hold_cnt == HOLD_LIMIT) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A GRANT exit with the request still high can only be the timeout, so the
    // request level doubles as the hold_expired flag and a drop always wins.
    always_comb begin
        next_gnt          = 8'h00;
        next_gnt_id       = last_id;
        next_gnt_valid    = 1'b0;
        next_hold_expired = 1'b0;
        next_hold_cnt     = 4'd0;
        next_last_id      = last_id;
        case (state)
            IDLE: begin
                if (req != 8'h00) begin
                    next_gnt       = 8'h01 << winner;
                    next_gnt_id    = winner;
                    next_gnt_valid = 1'b1;
                    next_last_id   = winner;
                    next_hold_cnt  = 4'd1;
                end
            end
            GRANT: begin
                if (next_state == GRANT) begin
                    next_gnt       = gnt;
                    next_gnt_id    = gnt_id;
                    next_gnt_valid = 1'b1;
                    next_hold_cnt  = hold_cnt + 4'd1;
                end else begin
                    next_hold_expired = req[gnt_id];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_priority_arbiter8.sv
// Directed bench for priority_arbiter8: three instances with different hold
// limits share one stimulus stream, and each scenario checks the relevant one.
module tb_priority_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;

    logic [7:0] gnt8, gnt2, gnt3;
    logic [2:0] id8, id2, id3;
    logic       v8, v2, v3;
    logic       he8, he2, he3;

    int vectors;
    int miscompares;
    bit chk_en;

    priority_arbiter8 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8), .hold_expired(he8)
    );

    priority_arbiter8 #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt2), .gnt_id(id2), .gnt_valid(v2), .hold_expired(he2)
    );

    priority_arbiter8 #(.MAX_HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt3), .gnt_id(id3), .gnt_valid(v3), .hold_expired(he3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic rr);
        req   = r;
        rr_en = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(8'h00, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] onehotOf(input logic v, input logic [2:0] id);
        return v ? (8'h01 << id) : 8'h00;
    endfunction

    // Structural invariants on every instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cons8", gnt8, onehotOf(v8, id8));
            checkOutput("cons2", gnt2, onehotOf(v2, id2));
            checkOutput("cons3", gnt3, onehotOf(v3, id3));
            checkOutput("onehot8", 8'($countones(gnt8) <= 1), 8'd1);
            checkOutput("onehot2", 8'($countones(gnt2) <= 1), 8'd1);
            checkOutput("onehot3", 8'($countones(gnt3) <= 1), 8'd1);
        end
    end

    initial begin
        logic [7:0] rr_exp;
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        rst_n       = 1'b0;
        applyStimulus(8'h00, 1'b0);
        tick();
        tick();
        chk_en = 1'b1;

        checkOutput("rst_gnt", gnt8, 8'h00);
        checkOutput("rst_id", 8'(id8), 8'd0);
        checkOutput("rst_valid", 8'(v8), 8'd0);
        checkOutput("rst_he", 8'(he8), 8'd0);
        rst_n = 1'b1;

        // Fixed priority: highest index wins, others ignored while granted.
        applyStimulus(8'h51, 1'b0);
        tick();
        checkOutput("fix_gnt", gnt8, 8'h40);
        checkOutput("fix_id", 8'(id8), 8'd6);
        checkOutput("fix_valid", 8'(v8), 8'd1);
        tick();
        checkOutput("fix_hold", gnt8, 8'h40);
        applyStimulus(8'h11, 1'b0);
        tick();
        checkOutput("fix_rel_gnt", gnt8, 8'h00);
        checkOutput("fix_rel_valid", 8'(v8), 8'd0);
        checkOutput("fix_rel_he", 8'(he8), 8'd0);
        checkOutput("fix_rel_id", 8'(id8), 8'd6);
        tick();
        checkOutput("fix_idle_gnt", gnt8, 8'h00);
        tick();
        checkOutput("fix_next_gnt", gnt8, 8'h10);
        checkOutput("fix_next_id", 8'(id8), 8'd4);
        applyStimulus(8'h00, 1'b0);
        tick();
        tick();

        // Round-robin with MAX_HOLD=2: 0x80, 0x01, 0x80, each timing out.
        doReset();
        applyStimulus(8'h81, 1'b1);
        for (int g = 0; g < 3; g++) begin
            rr_exp = (g == 1) ? 8'h01 : 8'h80;
            tick();
            checkOutput("rr_gnt_c1", gnt2, rr_exp);
            tick();
            checkOutput("rr_gnt_c2", gnt2, rr_exp);
            tick();
            checkOutput("rr_rel_gnt", gnt2, 8'h00);
            checkOutput("rr_rel_he", 8'(he2), 8'd1);
            if (g == 2) applyStimulus(8'h00, 1'b1);
            tick();
            checkOutput("rr_idle_gnt", gnt2, 8'h00);
            checkOutput("rr_idle_he", 8'(he2), 8'd0);
        end

        // Request drop on the same edge the MAX_HOLD=2 limit is reached.
        doReset();
        applyStimulus(8'h08, 1'b0);
        tick();
        checkOutput("sim_gnt_c1", gnt2, 8'h08);
        tick();
        checkOutput("sim_gnt_c2", gnt2, 8'h08);
        applyStimulus(8'h00, 1'b0);
        tick();
        checkOutput("sim_rel_gnt", gnt2, 8'h00);
        checkOutput("sim_rel_he", 8'(he2), 8'd0);
        tick();
        checkOutput("sim_idle_he", 8'(he2), 8'd0);

        // Timeout with MAX_HOLD=3 and the request held throughout.
        doReset();
        applyStimulus(8'h04, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("to_gnt", gnt3, 8'h04);
        end
        tick();
        checkOutput("to_rel_gnt", gnt3, 8'h00);
        checkOutput("to_rel_he", 8'(he3), 8'd1);
        tick();
        checkOutput("to_idle_gnt", gnt3, 8'h00);
        checkOutput("to_idle_he", 8'(he3), 8'd0);
        tick();
        checkOutput("to_regrant", gnt3, 8'h04);
        applyStimulus(8'h00, 1'b0);
        tick();
        tick();

        // Reset in the middle of a grant, then round-robin restarts from 7.
        doReset();
        applyStimulus(8'h20, 1'b0);
        tick();
        checkOutput("mid_gnt", gnt8, 8'h20);
        rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_gnt", gnt8, 8'h00);
        checkOutput("mid_rst_id", 8'(id8), 8'd0);
        checkOutput("mid_rst_valid", 8'(v8), 8'd0);
        checkOutput("mid_rst_he", 8'(he8), 8'd0);
        rst_n = 1'b1;
        applyStimulus(8'h21, 1'b1);
        tick();
        checkOutput("post_rst_gnt", gnt8, 8'h20);
        checkOutput("post_rst_id", 8'(id8), 8'd5);

        applyStimulus(8'h00, 1'b0);
        tick();
        tick();
        chk_en = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
